// File: rtl/dff_pkg.sv
// dff_pkg: shared constants and types for the generic register bank.
// Provides the default word width, default reset value and word type.
package dff_pkg;

    localparam int DFF_WIDTH_DEFAULT = 32;

    localparam logic [DFF_WIDTH_DEFAULT-1:0] DFF_RESET_DEFAULT = 32'h0;

    typedef logic [DFF_WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/dff1_r.sv
// dff1_r: single-bit flip-flop with synchronous active-low reset.
// Ports: clk, reset_n, d, q; en only with DFF32_R_CLK_ENABLE_EN defined.
module dff1_r #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
`ifdef DFF32_R_CLK_ENABLE_EN
    input  logic en,
`endif
    input  logic d,
    output logic q
);

    // Reset wins over both data and enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RST_BIT;
`ifdef DFF32_R_CLK_ENABLE_EN
        end else if (en) begin
            q <= d;
`else
        end else begin
            q <= d;
`endif
        end
    end

endmodule

// File: rtl/dff32_r.sv
// dff32_r: WIDTH-bit register bank built from dff1_r cells.
// Ports: clk, reset_n (sync, active-low), d, q; en with DFF32_R_CLK_ENABLE_EN.
module dff32_r
    import dff_pkg::*;
#(
    parameter int                 WIDTH       = DFF_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef DFF32_R_CLK_ENABLE_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("dff32_r: WIDTH must be in 1..64");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff1_r #(
            .RST_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
`ifdef DFF32_R_CLK_ENABLE_EN
            .en      (en),
`endif
            .d       (d[i]),
            .q       (q[i])
        );
    end

endmodule

// File: tb/tb_dff32_r.sv
// tb_dff32_r: directed self-checking bench for dff32_r.
// Covers a 32-bit default instance and an 8-bit instance with reset 8'hA5.
`timescale 1ns/1ps
module tb_dff32_r;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] d;
    logic [31:0] q;
    logic [7:0]  d8;
    logic [7:0]  q8;
`ifdef DFF32_R_CLK_ENABLE_EN
    logic        en;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] vec [7] = '{
        32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hABCD_EF00,
        32'h3579_1848, 32'hA7B1_F4D2, 32'h0E11_0230
    };
    logic [31:0] prev;

    always #10 clk = ~clk;

    dff32_r u_dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF32_R_CLK_ENABLE_EN
        .en      (en),
`endif
        .d       (d),
        .q       (q)
    );

    dff32_r #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef DFF32_R_CLK_ENABLE_EN
        .en      (en),
`endif
        .d       (d8),
        .q       (q8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        d       = 32'h0000_0000;
        d8      = 8'h00;
`ifdef DFF32_R_CLK_ENABLE_EN
        en      = 1'b1;
`endif
        // Reset at the first edge (10 ns), sampled at the falling edge.
        @(posedge clk);
        @(negedge clk);
        chk("rst_q", {32'h0, q}, 64'h0);
        chk("rst_q8", {56'h0, q8}, 64'hA5);
        d  = 32'hFFFF_FFFF;
        d8 = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_q", {32'h0, q}, 64'h0);
        chk("rst_hold_q8", {56'h0, q8}, 64'hA5);

        // Capture sequence; reset released 3 ns after an edge.
        prev = 32'h0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #3;
            reset_n = 1'b1;
            d = vec[i];
            @(negedge clk);
            chk("cap_early", {32'h0, q}, {32'h0, prev});
            @(posedge clk);
            @(negedge clk);
            chk("cap", {32'h0, q}, {32'h0, vec[i]});
            if (i == 0)
                chk("cap_q8", {56'h0, q8}, 64'h3C);
            prev = vec[i];
        end

        // Reset pulse between edges must not affect q.
        d = 32'h1234_5678;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #5;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_pulse", {32'h0, q}, 64'h1234_5678);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_sync", {32'h0, q}, 64'h0);
        chk("rst_sync_q8", {56'h0, q8}, 64'hA5);

        // Glitches on d between edges; only the final value is captured.
        reset_n = 1'b1;
        d = 32'hDEAD_BEEF;
        #2;
        d = 32'h0000_0001;
        #2;
        d = 32'hCAFE_F00D;
        #2;
        chk("glitch_early", {32'h0, q}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("glitch", {32'h0, q}, 64'hCAFE_F00D);

`ifdef DFF32_R_CLK_ENABLE_EN
        en = 1'b0;
        d  = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        chk("en_hold", {32'h0, q}, 64'hCAFE_F00D);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_cap", {32'h0, q}, 64'h5555_AAAA);
        en = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_rst", {32'h0, q}, 64'h0);
        chk("en_rst_q8", {56'h0, q8}, 64'hA5);
`else
        d = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        chk("noen_cap", {32'h0, q}, 64'h5555_AAAA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
